spi_sd_master: RTL and testbench

Register-mapped SPI master for the SD card sockets and other SPI peripherals on the 6309 bus. It replaces the tied-off nSD0/nSD1/MOSI/SCLK outputs of the glue CPLD. The block sits behind the $FExx I/O decoder: the decoder supplies nCS, the 6309 supplies RW, A[1:0] and data, and the block runs entirely on the 48 MHz master clock. It is parametrised in chip-select count, SPI mode and SCLK divider.

---
 rtl/spi_sd_master_if.sv | 31 +++
 rtl/spi_sd_master.sv | 200 ++++++++++++++++++++
 tb/tb_spi_sd_master.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_sd_master_if.sv
// Bus and pin bundle for spi_sd_master: 6309 register window on one side,
// SPI pins and chip selects on the other.
interface spi_sd_master_if #(
    parameter int NSEL = 2
);
    logic            nE;
    logic            nCS;
    logic            RW;
    logic [1:0]      A;
    logic [7:0]      DIN;
    logic [7:0]      DOUT;
    logic            DOE;
    logic            SCLK;
    logic            MOSI;
    logic            MISO;
    logic [NSEL-1:0] nSD;
    logic            BUSY;
    logic            DBG_STATE;

    // CPU handshake: a write commits on the clock edge that sees nE rise
    // (registered nE still low) with nCS=0 and RW=0; reads are side-effect free.
    modport slave (
        input  nE, nCS, RW, A, DIN, MISO,
        output DOUT, DOE, SCLK, MOSI, nSD, BUSY, DBG_STATE
    );

    modport master (
        output nE, nCS, RW, A, DIN, MISO,
        input  DOUT, DOE, SCLK, MOSI, nSD, BUSY, DBG_STATE
    );
endinterface

// File: rtl/spi_sd_master.sv
// Register-mapped SPI master on the 6309 bus: DATA/CTRL/SEL/DIV registers,
// byte-wide mode 0..3 transfers with a programmable SCLK divider.
module spi_sd_master #(
    parameter int NSEL    = 2,
    parameter int DIV_RST = 59
) (
    input  logic              MHZ48,
    input  logic              nRES,
    spi_sd_master_if.slave    bus
);
    localparam logic [7:0] DIV_RST_8 = 8'(DIV_RST);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic            r_ne_q;
    logic            r_miso_s1;
    logic            r_miso_s2;
    logic            r_cpol;
    logic            r_cpha;
    logic [NSEL-1:0] r_sel;
    logic [7:0]      r_div;
    logic [7:0]      r_div_cnt;
    logic [3:0]      r_edge;
    logic [7:0]      r_tx;
    logic [7:0]      r_rx;
    logic [7:0]      r_data;
    logic            r_sclk;
    logic            r_mosi;
    logic            r_ovr;

    logic            w_commit;
    logic            w_wr_data;
    logic            w_wr_ctrl;
    logic            w_wr_sel;
    logic            w_wr_div;
    logic            w_idle;
    logic            w_load;
    logic            w_tc;
    logic            w_done;
    logic            w_odd;
    logic            w_shift;
    logic            w_sample;
    logic [7:0]      w_sel_rd;

    assign w_commit  = ~r_ne_q & bus.nE & ~bus.nCS & ~bus.RW;
    assign w_wr_data = w_commit & (bus.A == 2'd0);
    assign w_wr_ctrl = w_commit & (bus.A == 2'd1);
    assign w_wr_sel  = w_commit & (bus.A == 2'd2);
    assign w_wr_div  = w_commit & (bus.A == 2'd3);
    assign w_idle    = (r_state == S_IDLE);

    always_ff @(posedge MHZ48 or negedge nRES) begin
        if (!nRES) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_tc         = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_wr_data) begin
                    w_load       = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_tc = (r_div_cnt == r_div);
                if (w_tc && (r_edge == 4'd15)) begin
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // r_edge holds (edge number - 1), so an even count means an odd edge.
    assign w_odd    = ~r_edge[0];
    assign w_shift  = w_tc & (r_cpha ? w_odd : ~w_odd);
    assign w_sample = w_tc & (r_cpha ? ~w_odd : w_odd);

    always_ff @(posedge MHZ48 or negedge nRES) begin
        if (!nRES) begin
            r_ne_q    <= 1'b1;
            r_miso_s1 <= 1'b1;
            r_miso_s2 <= 1'b1;
        end else begin
            r_ne_q    <= bus.nE;
            r_miso_s1 <= bus.MISO;
            r_miso_s2 <= r_miso_s1;
        end
    end

    // Configuration only changes between transfers; busy-time writes are dropped.
    always_ff @(posedge MHZ48 or negedge nRES) begin
        if (!nRES) begin
            r_cpol <= 1'b0;
            r_cpha <= 1'b0;
            r_sel  <= '0;
            r_div  <= DIV_RST_8;
            r_ovr  <= 1'b0;
        end else begin
            if (w_idle && w_wr_ctrl) begin
                r_cpol <= bus.DIN[1];
                r_cpha <= bus.DIN[0];
            end
            if (w_idle && w_wr_sel) begin
                r_sel <= bus.DIN[NSEL-1:0];
            end
            if (w_idle && w_wr_div) begin
                r_div <= bus.DIN;
            end
            if (w_wr_data) begin
                r_ovr <= ~w_idle;
            end
        end
    end

    always_ff @(posedge MHZ48 or negedge nRES) begin
        if (!nRES) begin
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b1;
            r_div_cnt <= '0;
            r_edge    <= '0;
            r_tx      <= 8'hFF;
            r_rx      <= 8'hFF;
            r_data    <= 8'hFF;
        end else begin
            if (w_idle) begin
                r_sclk <= r_cpol;
            end else if (w_tc) begin
                r_sclk <= ~r_sclk;
            end

            if (w_load || w_tc) begin
                r_div_cnt <= '0;
            end else if (!w_idle) begin
                r_div_cnt <= r_div_cnt + 8'd1;
            end

            if (w_load) begin
                r_edge <= '0;
            end else if (w_tc) begin
                r_edge <= r_edge + 4'd1;
            end

            // CPHA=0 presents bit7 immediately; CPHA=1 waits for the first edge.
            if (w_load) begin
                r_tx   <= r_cpha ? bus.DIN : {bus.DIN[6:0], 1'b1};
                r_mosi <= r_cpha ? 1'b1 : bus.DIN[7];
            end else if (w_done) begin
                r_mosi <= 1'b1;
            end else if (w_shift) begin
                r_mosi <= r_tx[7];
                r_tx   <= {r_tx[6:0], 1'b1};
            end

            if (w_sample) begin
                r_rx <= {r_rx[6:0], r_miso_s2};
            end

            // In CPHA=1 the 8th sample lands on edge 16 itself.
            if (w_done) begin
                r_data <= r_cpha ? {r_rx[6:0], r_miso_s2} : r_rx;
            end
        end
    end

    always_comb begin
        w_sel_rd             = '0;
        w_sel_rd[NSEL-1:0]   = r_sel;
        bus.DOUT             = r_data;
        case (bus.A)
            2'd0: bus.DOUT = r_data;
            2'd1: bus.DOUT = {~w_idle, r_ovr, 4'b0000, r_cpol, r_cpha};
            2'd2: bus.DOUT = w_sel_rd;
            2'd3: bus.DOUT = r_div;
            default: bus.DOUT = r_data;
        endcase
    end

    assign bus.DOE       = ~bus.nCS & bus.RW & ~bus.nE;
    assign bus.SCLK      = r_sclk;
    assign bus.MOSI      = r_mosi;
    assign bus.nSD       = ~r_sel;
    assign bus.BUSY      = ~w_idle;
    assign bus.DBG_STATE = r_state;
endmodule

// File: tb/tb_spi_sd_master.sv
// Directed bench for spi_sd_master: bus reads are checked by a scoreboard
// monitor, pins and SPI traffic by direct checks against a slave model.
module tb_spi_sd_master;
  localparam int NSEL = 2;

  logic MHZ48 = 1'b0;
  logic nRES  = 1'b1;

  spi_sd_master_if #(.NSEL(NSEL)) bus ();

  spi_sd_master #(.NSEL(NSEL), .DIV_RST(59)) dut (
    .MHZ48 (MHZ48),
    .nRES  (nRES),
    .bus   (bus)
  );

  // clock / reset
  always #10 MHZ48 = ~MHZ48;

  int cyc = 0;
  always @(posedge MHZ48) cyc++;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  string      name_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // scoreboard monitor: one pop per read bus cycle (DOE rising)
  logic       doe_prev = 1'b0;
  logic [7:0] m_exp;
  string      m_name;
  always @(negedge MHZ48) begin
    if (bus.DOE === 1'b1 && doe_prev !== 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read: got 0x%0h, expected no read", bus.DOUT);
      end else begin
        m_exp  = exp_q.pop_front();
        m_name = name_q.pop_front();
        if (bus.DOUT !== m_exp) begin
          failures++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h", m_name, bus.DOUT, m_exp);
        end
      end
    end
    doe_prev = bus.DOE;
  end

  // BUSY length monitor
  int busy_rise_cyc = 0;
  int busy_fall_cyc = 0;
  always @(posedge bus.BUSY) busy_rise_cyc = cyc;
  always @(negedge bus.BUSY) busy_fall_cyc = cyc;

  // SPI slave model
  logic       s_go = 1'b0;
  logic       s_go_seen;
  logic       s_cfg_cpol = 1'b0;
  logic       s_cfg_cpha = 1'b0;
  logic [7:0] s_load_tx  = 8'hFF;
  logic [7:0] s_tx;
  logic [7:0] s_rx;
  logic       s_miso;
  logic       s_lead;
  int         sclk_edges;
  int         sclk_rises;
  int         last_rise;
  int         rise_period;

  assign bus.MISO = s_miso;

  initial begin
    s_go_seen = 1'b0;
    s_tx = 8'hFF; s_rx = 8'h00; s_miso = 1'b1;
    sclk_edges = 0; sclk_rises = 0; last_rise = 0; rise_period = 0;
    forever begin
      @(bus.SCLK or s_go);
      if (s_go != s_go_seen) begin
        s_go_seen  = s_go;
        s_rx       = 8'h00;
        sclk_edges = 0; sclk_rises = 0; last_rise = 0; rise_period = 0;
        s_miso     = s_load_tx[7];
        s_tx       = s_cfg_cpha ? s_load_tx : {s_load_tx[6:0], 1'b1};
      end else begin
        sclk_edges++;
        s_lead = (bus.SCLK != s_cfg_cpol);
        if (bus.SCLK === 1'b1) begin
          sclk_rises++;
          if (last_rise != 0) rise_period = cyc - last_rise;
          last_rise = cyc;
        end
        if (s_lead == s_cfg_cpha) begin
          s_miso = s_tx[7];
          s_tx   = {s_tx[6:0], 1'b1};
        end else begin
          s_rx = {s_rx[6:0], bus.MOSI};
        end
      end
    end
  end

  // driver tasks
  task automatic slave_load(input logic cpol, input logic cpha, input logic [7:0] tx);
    s_cfg_cpol = cpol;
    s_cfg_cpha = cpha;
    s_load_tx  = tx;
    s_go       = ~s_go;
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(posedge MHZ48); #1;
    bus.nCS = 1'b0; bus.RW = 1'b0; bus.A = a; bus.DIN = d; bus.nE = 1'b0;
    repeat (3) @(posedge MHZ48);
    #1 bus.nE = 1'b1;
    @(posedge MHZ48); #1;
    bus.nCS = 1'b1; bus.RW = 1'b1;
    repeat (2) @(posedge MHZ48);
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [7:0] req, input string name);
    exp_q.push_back(req);
    name_q.push_back(name);
    @(posedge MHZ48); #1;
    bus.nCS = 1'b0; bus.RW = 1'b1; bus.A = a; bus.nE = 1'b0;
    repeat (3) @(posedge MHZ48);
    #1 bus.nE = 1'b1;
    @(posedge MHZ48); #1;
    bus.nCS = 1'b1;
    repeat (2) @(posedge MHZ48);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (bus.BUSY === 1'b1 && n < max_cycles) begin
      @(negedge MHZ48);
      n++;
    end
    if (bus.BUSY !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout: BUSY=%b after %0d cycles, expected 0", bus.BUSY, n);
    end
    @(negedge MHZ48);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.nE = 1'b1; bus.nCS = 1'b1; bus.RW = 1'b1; bus.A = 2'd0; bus.DIN = 8'h00;
    #5 nRES = 1'b0;
    repeat (3) @(posedge MHZ48);
    #1 nRES = 1'b1;
    @(negedge MHZ48);

    // reset state
    check("rst_nsd",  32'(bus.nSD),  32'h3);
    check("rst_mosi", 32'(bus.MOSI), 32'h1);
    check("rst_sclk", 32'(bus.SCLK), 32'h0);
    check("rst_busy", 32'(bus.BUSY), 32'h0);
    check("rst_doe",  32'(bus.DOE),  32'h0);
    bus_read(2'd0, 8'hFF, "rst_data");
    bus_read(2'd1, 8'h00, "rst_status");
    bus_read(2'd2, 8'h00, "rst_sel");
    bus_read(2'd3, 8'd59, "rst_div");

    // mode 0, DIV=2, SEL=1, 0xA5 out, 0x3C in
    bus_write(2'd3, 8'd2);
    bus_write(2'd1, 8'h00);
    bus_write(2'd2, 8'h01);
    check("m0_nsd_sel", 32'(bus.nSD), 32'h2);
    slave_load(1'b0, 1'b0, 8'h3C);
    bus_write(2'd0, 8'hA5);
    wait_idle(200);
    check("m0_sclk_rises",  32'(sclk_rises),  32'd8);
    check("m0_sclk_period", 32'(rise_period), 32'd6);
    check("m0_mosi_byte",   32'(s_rx),        32'hA5);
    check("m0_busy_len",    32'(busy_fall_cyc - busy_rise_cyc), 32'd48);
    check("m0_nsd_after",   32'(bus.nSD),     32'h2);
    bus_read(2'd0, 8'h3C, "m0_data");

    // mode 3, DIV=0, 0x81 out, 0xFF in
    bus_write(2'd1, 8'h03);
    bus_write(2'd3, 8'd0);
    check("m3_sclk_idle_before", 32'(bus.SCLK), 32'h1);
    slave_load(1'b1, 1'b1, 8'hFF);
    bus_write(2'd0, 8'h81);
    wait_idle(100);
    check("m3_sclk_edges",      32'(sclk_edges), 32'd16);
    check("m3_mosi_byte",       32'(s_rx),       32'h81);
    check("m3_busy_len",        32'(busy_fall_cyc - busy_rise_cyc), 32'd16);
    check("m3_sclk_idle_after", 32'(bus.SCLK),   32'h1);
    bus_read(2'd0, 8'hFF, "m3_data");
    bus_read(2'd1, 8'h03, "m3_status");

    // overrun: second DATA write while busy
    bus_write(2'd1, 8'h00);
    bus_write(2'd3, 8'd7);
    slave_load(1'b0, 1'b0, 8'h96);
    bus_write(2'd0, 8'h5A);
    bus_write(2'd0, 8'h55);
    bus_read(2'd1, 8'hC0, "ovr_status_busy");
    wait_idle(400);
    bus_read(2'd1, 8'h40, "ovr_status_done");
    check("ovr_mosi_byte", 32'(s_rx), 32'h5A);
    bus_read(2'd0, 8'h96, "ovr_data");

    // accepted write clears OVR; SEL/DIV writes while busy are dropped
    slave_load(1'b0, 1'b0, 8'h00);
    bus_write(2'd0, 8'h11);
    bus_read(2'd1, 8'h80, "ovr_cleared");
    bus_write(2'd2, 8'h03);
    bus_write(2'd3, 8'h00);
    bus_read(2'd2, 8'h01, "busy_sel_kept");
    check("busy_nsd_kept", 32'(bus.nSD), 32'h2);
    bus_read(2'd3, 8'h07, "busy_div_kept");
    wait_idle(400);
    bus_read(2'd1, 8'h00, "status_idle");
    check("tx11_mosi_byte", 32'(s_rx), 32'h11);
    bus_read(2'd0, 8'h00, "tx11_data");

    // reset mid-transfer
    bus_write(2'd3, 8'd2);
    slave_load(1'b0, 1'b0, 8'h00);
    bus_write(2'd0, 8'h00);
    begin
      int n;
      n = 0;
      while (sclk_edges < 5 && n < 200) begin
        @(negedge MHZ48);
        n++;
      end
      check("rr_edges_reached", 32'(sclk_edges >= 5), 32'h1);
    end
    check("rr_busy_before", 32'(bus.BUSY), 32'h1);
    nRES = 1'b0;
    #1;
    check("rr_sclk", 32'(bus.SCLK), 32'h0);
    check("rr_mosi", 32'(bus.MOSI), 32'h1);
    check("rr_nsd",  32'(bus.nSD),  32'h3);
    check("rr_busy", 32'(bus.BUSY), 32'h0);
    @(posedge MHZ48);
    #1 nRES = 1'b1;
    bus_read(2'd0, 8'hFF, "rr_data");
    bus_read(2'd3, 8'd59, "rr_div");
    bus_read(2'd2, 8'h00, "rr_sel");

    repeat (2) @(negedge MHZ48);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
